mesh_router_wh: RTL

- Parametrised successor of the 5-port mesh router node: wormhole-switched, credit flow-controlled router with XY routing and a configurable number of local (PE) ports.
- Each input has a flit FIFO. Each output has a round-robin arbiter with packet lock, a credit counter and a registered output stage.
- Sits at every mesh tile. Neighbour links connect to identical instances; local ports connect to PE network interfaces.

---
 rtl/mesh_router_pkg.sv | 24 ++
 rtl/mesh_router_wh_in_fifo.sv | 32 +++
 rtl/mesh_router_wh.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mesh_router_pkg.sv
// mesh_router_pkg: flit encodings, port indices and header field offsets for mesh_router_wh.
package mesh_router_pkg;
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;
  typedef enum logic {OUT_IDLE, OUT_LOCKED} out_state_e;
  localparam int PORT_XP = 0;
  localparam int PORT_XM = 1;
  localparam int PORT_YP = 2;
  localparam int PORT_YM = 3;
  localparam int PORT_LOCAL0 = 4;
  function automatic int dx_lsb(int dw, int cw);
    return dw - 2 - cw;
  endfunction
  function automatic int dy_lsb(int dw, int cw);
    return dw - 2 - 2 * cw;
  endfunction
  function automatic int li_lsb(int dw, int cw, int lpw);
    return dw - 2 - 2 * cw - lpw;
  endfunction
endpackage

// File: rtl/mesh_router_wh_in_fifo.sv
// router_in_fifo: flop-based input flit FIFO with wrap-bit pointers.
module router_in_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/mesh_router_wh.sv
// mesh_router_wh: wormhole XY mesh router with credit flow control and per-output RR arbiters.
// Define MESH_ROUTER_OVF_DETECT_EN to get sticky per-input drop flags on overflow_err.
module mesh_router_wh
  import mesh_router_pkg::*;
#(
  parameter int XCOR = 2,
  parameter int YCOR = 2,
  parameter int COORD_W = 4,
  parameter int LOCAL_PORTS = 1,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int P = 4 + LOCAL_PORTS,
  localparam int LP_W = LOCAL_PORTS > 1 ? $clog2(LOCAL_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P-1:0]          in_valid,
  input  logic [P*DATA_WIDTH-1:0] in_flit,
  output logic [P-1:0]          in_credit_ret,
  output logic [P-1:0]          out_valid,
  output logic [P*DATA_WIDTH-1:0] out_flit,
  input  logic [P-1:0]          out_credit_in,
  output logic [P-1:0]          overflow_err
);
  localparam int PW = $clog2(P);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DXL = dx_lsb(DATA_WIDTH, COORD_W);
  localparam int DYL = dy_lsb(DATA_WIDTH, COORD_W);
  localparam int LIL = li_lsb(DATA_WIDTH, COORD_W, LP_W);
  function automatic logic [PW-1:0] route(input logic [DATA_WIDTH-1:0] f);
    logic [COORD_W-1:0] dx, dy;
    logic [LP_W-1:0] li;
    dx = f[DXL+:COORD_W];
    dy = f[DYL+:COORD_W];
    li = f[LIL+:LP_W];
    return dx > COORD_W'(XCOR) ? PW'(PORT_XP) :
           dx < COORD_W'(XCOR) ? PW'(PORT_XM) :
           dy > COORD_W'(YCOR) ? PW'(PORT_YP) :
           dy < COORD_W'(YCOR) ? PW'(PORT_YM) :
           ({1'b0, li} < (LP_W+1)'(LOCAL_PORTS)) ? PW'(PORT_LOCAL0) + PW'(li) : PW'(PORT_LOCAL0);
  endfunction
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v >= P ? v - P : v);
  endfunction
  logic [P-1:0] fifo_full, fifo_empty, pop, req, send;
  logic [DATA_WIDTH-1:0] head [P];
  logic [PW-1:0] dst [P];
  out_state_e st [P];
  out_state_e st_n [P];
  logic [PW-1:0] own [P];
  logic [PW-1:0] own_n [P];
  logic [PW-1:0] rr [P];
  logic [PW-1:0] rr_n [P];
  logic [PW-1:0] sel [P];
  logic [PW-1:0] cand;
  logic [CW-1:0] cred [P];
  for (genvar i = 0; i < P; i++) begin : g_in
    router_in_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(in_valid[i] && !fifo_full[i]),
      .pop(pop[i]),
      .din(in_flit[i*DATA_WIDTH+:DATA_WIDTH]),
      .full(fifo_full[i]),
      .empty(fifo_empty[i]),
      .head(head[i])
    );
    assign dst[i] = route(head[i]);
    assign req[i] = !fifo_empty[i] && (flit_type_e'(head[i][DATA_WIDTH-1-:2]) inside {FLIT_HEAD, FLIT_SINGLE});
  end
  // Descending scan so the last hit written is the first eligible input from rr.
  always_comb begin
    pop = '0;
    send = '0;
    cand = '0;
    for (int o = 0; o < P; o++) begin
      st_n[o] = st[o];
      own_n[o] = own[o];
      rr_n[o] = rr[o];
      sel[o] = own[o];
      if (st[o] == OUT_LOCKED) send[o] = !fifo_empty[own[o]] && cred[o] != '0;
      else
        for (int k = P - 1; k >= 0; k--) begin
          cand = wrap(int'(rr[o]) + k);
          if (req[cand] && dst[cand] == PW'(o)) begin
            sel[o] = cand;
            send[o] = cred[o] != '0;
          end
        end
      if (send[o]) begin
        pop[sel[o]] = 1'b1;
        if (st[o] == OUT_IDLE) begin
          rr_n[o] = wrap(int'(sel[o]) + 1);
          own_n[o] = sel[o];
          st_n[o] = flit_type_e'(head[sel[o]][DATA_WIDTH-1-:2]) == FLIT_HEAD ? OUT_LOCKED : OUT_IDLE;
        end else if (flit_type_e'(head[own[o]][DATA_WIDTH-1-:2]) inside {FLIT_TAIL, FLIT_SINGLE})
          st_n[o] = OUT_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_flit <= '0;
      in_credit_ret <= '0;
      for (int o = 0; o < P; o++) begin
        st[o] <= OUT_IDLE;
        own[o] <= '0;
        rr[o] <= '0;
        cred[o] <= CW'(FIFO_DEPTH);
      end
    end else begin
      out_valid <= send;
      in_credit_ret <= pop;
      for (int o = 0; o < P; o++) begin
        st[o] <= st_n[o];
        own[o] <= own_n[o];
        rr[o] <= rr_n[o];
        if (send[o]) out_flit[o*DATA_WIDTH+:DATA_WIDTH] <= head[sel[o]];
        if (send[o] && !out_credit_in[o]) cred[o] <= cred[o] - 1'b1;
        else if (!send[o] && out_credit_in[o] && cred[o] != CW'(FIFO_DEPTH)) cred[o] <= cred[o] + 1'b1;
      end
    end
  end
`ifdef MESH_ROUTER_OVF_DETECT_EN
  always_ff @(posedge clk)
    if (rst) overflow_err <= '0;
    else overflow_err <= overflow_err | (in_valid & fifo_full);
`else
  assign overflow_err = '0;
`endif
endmodule
